// File: rtl/multiplier.sv
// Sequential 32x32 unsigned shift-add multiplier. The product is built in
// exactly 32 iterations and published on dataOut with a one-cycle done pulse.
module multiplier #(
    parameter logic [5:0] MULTU = 6'b011001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    input  logic [5:0]  Signal,
    output logic [63:0] dataOut,
    output logic        busy,
    output logic        done
);

    localparam int unsigned W     = 32;
    localparam int unsigned CNT_W = 6;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic [W-1:0]      mcand;
    logic [2*W-1:0]    product;

    logic [W:0]        sum_c;
    logic [2*W-1:0]    shifted_c;

    // One shift-add step: conditional add into the upper half, carry kept,
    // then a 65-bit right shift so the carry lands in bit 63.
    always_comb begin
        sum_c     = {1'b0, product[2*W-1:W]};
        if (product[0]) begin
            sum_c = {1'b0, product[2*W-1:W]} + {1'b0, mcand};
        end
        shifted_c = {sum_c, product[W-1:1]};
    end

    // Control FSM, iteration datapath and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            mcand   <= '0;
            product <= '0;
            dataOut <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (Signal == MULTU) begin
                        mcand   <= dataA;
                        product <= {{W{1'b0}}, dataB};
                        count   <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    product <= shifted_c;
                    count   <= count + CNT_W'(1);
                    if (count == LAST_ITER) begin
                        dataOut <= shifted_c;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= DONE;
                    end else begin
                        busy    <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for the sequential multiplier: directed vector table,
// randomized operands against plain 64-bit arithmetic, and timing corner cases.
module tb_multiplier;

    localparam logic [5:0] MULTU = 6'b011001;

    logic        clk;
    logic        reset;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [5:0]  Signal;
    logic [63:0] dataOut;
    logic        busy;
    logic        done;

    int checks;
    int errors;
    logic [63:0] last_result;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[7];

    multiplier #(.MULTU(MULTU)) dut (
        .clk     (clk),
        .reset   (reset),
        .dataA   (dataA),
        .dataB   (dataB),
        .Signal  (Signal),
        .dataOut (dataOut),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Starts one operation and follows it to T+33. When disturb is set the
    // inputs are scrambled (with Signal=MULTU) from T+10 until T+31.
    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input bit disturb);
        int busy_cycles;
        int early_done;
        busy_cycles = 0;
        early_done  = 0;
        dataA  = a;
        dataB  = b;
        Signal = MULTU;
        @(posedge clk); #1;                 // edge T
        Signal = 6'd0;
        dataA  = $urandom;
        dataB  = $urandom;
        check1({name, " busy after T"}, busy, 1'b0);
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk); #1;             // edge T+k
            if (k < 32) begin
                if (busy === 1'b1) busy_cycles++;
                if (done !== 1'b0) early_done++;
            end
            if (k == 16) check64({name, " dataOut held in RUN"}, dataOut, last_result);
            if (disturb && k == 10) begin
                Signal = MULTU;
                dataA  = $urandom;
                dataB  = $urandom;
            end
            if (disturb && k == 31) Signal = 6'd0;
        end
        check_int({name, " busy cycles"}, busy_cycles, 31);
        check_int({name, " early done"}, early_done, 0);
        check1({name, " done at T+32"}, done, 1'b1);
        check1({name, " busy at T+32"}, busy, 1'b0);
        check64({name, " dataOut"}, dataOut, exp);
        last_result = exp;
        @(posedge clk); #1;                 // edge T+33
        check1({name, " done at T+33"}, done, 1'b0);
        check64({name, " dataOut after done"}, dataOut, exp);
    endtask

    initial begin
        int busy_seen;
        int done_seen;
        logic [31:0] ra;
        logic [31:0] rb;
        checks      = 0;
        errors      = 0;
        last_result = 64'd0;

        vecs[0] = '{32'd7,          32'd6,          64'd42};
        vecs[1] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   64'hFFFFFFFE00000001};
        vecs[2] = '{32'd0,          32'h12345678,   64'd0};
        vecs[3] = '{32'h80000000,   32'd2,          64'h0000000100000000};
        vecs[4] = '{32'd1,          32'hFFFFFFFF,   64'h00000000FFFFFFFF};
        vecs[5] = '{32'hFFFFFFFF,   32'd1,          64'h00000000FFFFFFFF};
        vecs[6] = '{32'h00010000,   32'h00010000,   64'h0000000100000000};

        reset  = 1'b1;
        dataA  = 32'd0;
        dataB  = 32'd0;
        Signal = MULTU;
        repeat (3) @(posedge clk);
        #1;
        check64("reset dataOut", dataOut, 64'd0);
        check1("reset busy", busy, 1'b0);
        check1("reset done", done, 1'b0);
        reset  = 1'b0;
        Signal = 6'd0;

        // Non-start opcode must leave the block idle.
        Signal = MULTU ^ 6'b000001;
        repeat (5) @(posedge clk);
        #1;
        check1("bad opcode busy", busy, 1'b0);
        check1("bad opcode done", done, 1'b0);
        check64("bad opcode dataOut", dataOut, 64'd0);

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0);
        end

        // Inputs changed mid-run must neither alter the result nor restart.
        run_op("disturb", 32'd3, 32'd5, 64'd15, 1'b1);
        busy_seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (busy === 1'b1 || done === 1'b1) busy_seen++;
        end
        check_int("no extra start", busy_seen, 0);

        // Reset between edges during RUN aborts with no done pulse.
        dataA  = 32'd11;
        dataB  = 32'd13;
        Signal = MULTU;
        @(posedge clk); #1;
        Signal = 6'd0;
        repeat (15) @(posedge clk);
        #2;
        check1("pre-abort busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        check1("abort busy", busy, 1'b0);
        check1("abort done", done, 1'b0);
        check64("abort dataOut", dataOut, 64'd0);
        #1;
        reset = 1'b0;
        last_result = 64'd0;
        done_seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) done_seen++;
        end
        check_int("no done after abort", done_seen, 0);
        run_op("after abort", 32'd123456, 32'd654321, 64'd123456 * 64'd654321, 1'b0);

        // Signal held at MULTU: restarts every 34 cycles.
        dataA  = 32'd2;
        dataB  = 32'd9;
        Signal = MULTU;
        @(posedge clk); #1;                 // edge T
        for (int k = 1; k <= 70; k++) begin
            @(posedge clk); #1;
            check1($sformatf("held done T+%0d", k), done, (k == 32 || k == 66));
            if (k == 32 || k == 66) check64($sformatf("held dataOut T+%0d", k), dataOut, 64'd18);
            if (k == 66) Signal = 6'd0;
        end
        last_result = 64'd18;

        // Randomized operands against a plain 64-bit product.
        for (int n = 0; n < 20; n++) begin
            ra = $urandom;
            rb = $urandom;
            if (n == 0) ra = 32'd0;
            if (n == 1) rb = 32'hFFFFFFFF;
            run_op($sformatf("rand%0d", n), ra, rb, 64'(ra) * 64'(rb), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
